fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Parametrised instruction-fetch front end for the RISC-V core. Owns the fetch PC and
//   issues pipelined requests to instruction memory over a valid/ready channel. Buffers
//   returned instructions, each tagged with its PC, in a DEPTH-entry prefetch FIFO.
//   Hands them to decode over a second valid/ready channel, and services branch/jump redirects.
// PARAMETERS
//   XLEN      32   width of PC and memory address (32 or 64)
//   DEPTH     4    prefetch FIFO entries = max in-flight + buffered instrs; power of 2, >=2
//   RESET_PC  0    fetch PC loaded on reset (XLEN bits, [1:0] must be 0)
// PORTS
//   clk             in   1     clock, all state updates on posedge
//   nrst            in   1     synchronous reset, active-high
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     memory accepts request this cycle
//   imem_req_addr   out  XLEN  fetch address (word aligned)
//   imem_rsp_valid  in   1     instruction word returned (in order, >=1 cycle after accept)
//   imem_rsp_data   in   32    returned instruction
//   redirect_valid  in   1     taken branch/jump: restart fetch at redirect_pc
//   redirect_pc     in   XLEN  redirect target; bits [1:0] ignored (treated as 0)
//   if_valid        out  1     FIFO head valid toward decode
//   if_ready        in   1     decode consumes head this cycle
//   if_inst         out  32    head instruction
//   if_pc           out  XLEN  PC of head instruction
// BEHAVIOUR
//   Reset (nrst=1 at posedge): fpc<=RESET_PC, rsp_pc<=RESET_PC, FIFO empty, outstanding=0,
//     drop=0, state<=FETCH. Outputs after reset: imem_req_valid=1, imem_req_addr=RESET_PC,
//     if_valid=0, if_inst=0, if_pc=0 (if_inst/if_pc are 0 whenever FIFO empty).
//   Counters: outstanding = accepted, not yet returned requests (width $clog2(DEPTH+1)).
//     credit = DEPTH - outstanding - fifo_count. Never negative; FIFO can never overflow.
//   imem_req_valid = (state==FETCH) && credit>0 && !redirect_valid. Must not depend on
//     imem_req_ready. imem_req_addr = fpc. Handshake = valid&&ready: fpc<=fpc+4 (wraps mod 2^XLEN).
//   Once raised, valid/addr stay stable until accepted; only redirect may withdraw them.
//   Response (state FETCH, no redirect): push {rsp_pc, imem_rsp_data}; rsp_pc<=rsp_pc+4.
//   Pop: if_valid&&if_ready removes head. Push and pop in the same cycle is legal at any count.
//   Latency: response registered into FIFO; if_valid rises cycle after imem_rsp_valid.
//     Zero-wait memory: req cycle 0, rsp cycle 1, if_valid cycle 2.
//   FSM states:
//     FETCH
//       - on redirect_valid: FIFO flushed.
//       - fpc<=redirect_pc&~3, rsp_pc<=redirect_pc&~3.
//       - drop <= outstanding + (req handshake this cycle) - (rsp this cycle).
//       - If drop would be >0, go to DRAIN; else stay in FETCH.
//       - A response in the redirect cycle is discarded.
//     DRAIN
//       - No requests issued. Each imem_rsp_valid is discarded and decrements drop.
//       - When drop reaches 0, go to FETCH (requests resume the next cycle).
//       - A further redirect in DRAIN overwrites fpc/rsp_pc, flushes the FIFO and keeps draining.
//   Redirect same cycle as if_valid&&if_ready: pop is irrelevant; if_valid=0 the next cycle.
//   Reset mid-operation: all state is re-initialised. In-flight responses are not tracked,
//     so the memory must also be reset.
//   Response with outstanding==0 is a protocol error; ignored (no push).
// TESTING
//   1 Reset, zero-wait mem, if_ready=1 -> if_pc 0,4,8,12... one per cycle from cycle 2;
//     if_inst matches mem.
//   2 if_ready=0, DEPTH=4 -> exactly 4 requests accepted (0..C), then req_valid=0.
//     Release if_ready -> 4 pops, fetching resumes at 0x10.
//   3 3-cycle mem latency, 2 in flight, redirect to 0x100 -> both late responses dropped.
//     First if_pc=0x100, no stale instr.
//   4 Redirect same cycle as req handshake and rsp -> drop count correct.
//     Next delivered if_pc = target; redirect_pc=0x103 yields if_pc=0x100.
//   5 Back-to-back redirects (0x40, then 0x80 while in DRAIN) -> only 0x80 stream delivered.
//   6 XLEN=64, RESET_PC=2^64-8 -> if_pc FF..F8, FF..FC, 0 (wrap); nrst mid-stream -> if_valid=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch front-end channels: imem request/response, redirect, and decode hand-off.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited pipelined imem requests, PC-tagged
// prefetch FIFO toward decode, redirect with drain of stale in-flight responses.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          nrst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];

  logic [CW-1:0]   credit;
  logic            req_valid;
  logic            req_hs;
  logic            rsp_ok;
  logic            head_valid;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  always_comb begin
    // Credit covers both in-flight and buffered entries, so the FIFO can never overflow.
    credit     = CW'(DEPTH) - outstanding_q - count_q;
    req_valid  = (state_q == FETCH) && (credit != '0) && !bus.redirect_valid;
    req_hs     = req_valid && bus.imem_req_ready;
    rsp_ok     = bus.imem_rsp_valid && (outstanding_q != '0);
    head_valid = (count_q != '0);
    target     = bus.redirect_pc & ~XLEN'(3);

    state_d       = state_q;
    fpc_d         = fpc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;
    push          = 1'b0;
    pop           = 1'b0;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(rsp_ok);

    if (req_hs) fpc_d = fpc_q + XLEN'(4);

    if (bus.redirect_valid) begin
      fpc_d    = target;
      rsp_pc_d = target;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    case (state_q)
      FETCH: begin
        if (bus.redirect_valid) begin
          drop_d  = outstanding_d;
          state_d = (outstanding_d != '0) ? DRAIN : FETCH;
        end else begin
          push = rsp_ok;
        end
      end
      DRAIN: begin
        if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if (drop_d == '0) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (!bus.redirect_valid) begin
      pop = head_valid && bus.if_ready;
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};
        wr_ptr_d        = wr_ptr_q + PW'(1);
        rsp_pc_d        = rsp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q       <= FETCH;
      fpc_q         <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the head is gated by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fpc_q;
  assign bus.if_valid       = head_valid;
  assign bus.if_inst        = head_valid ? mem_q[rd_ptr_q].inst : '0;
  assign bus.if_pc          = head_valid ? mem_q[rd_ptr_q].pc : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit: in-order memory model with variable
// latency, and a stream scoreboard that expects consecutive PCs from each redirect target.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst   = 1'b1;
  logic nrst64 = 1'b1;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(64)) bus64 ();

  fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );
  fetch_unit #(.XLEN(64), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut64 (
    .clk(clk), .nrst(nrst64), .bus(bus64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] acc_addr[$];
  int          cyc;
  int          lat_min, lat_max, p_rdy, p_ifr, p_redir;
  logic [31:0] exp_pc;
  int          n_pops;
  bit          redir_prev, stall_prev, want_first, got_first;
  logic [31:0] prev_addr, first_pc;
  bit          force_redir;
  logic [31:0] force_pc;
  logic        s_if_valid, s_req_valid;
  logic [31:0] s_if_pc;

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;
    mq.delete();
    acc_addr.delete();
    @(posedge clk);
    @(posedge clk);
    #1 nrst = 1'b0;
    cyc = 0; exp_pc = 32'h0; n_pops = 0;
    redir_prev = 0; stall_prev = 0; want_first = 0; got_first = 0; force_redir = 0;
    check_eq("rst_req_valid", bus.imem_req_valid, 1);
    check_eq("rst_req_addr", bus.imem_req_addr, 32'h0);
    check_eq("rst_if_valid", bus.if_valid, 0);
    check_eq("rst_if_inst", bus.if_inst, 0);
    check_eq("rst_if_pc", bus.if_pc, 0);
  endtask

  task automatic step();
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word({32'h0, mq[0].addr});
      void'(mq.pop_front());
    end
    bus.imem_req_ready = ($urandom_range(99, 0) < p_rdy);
    bus.if_ready       = ($urandom_range(99, 0) < p_ifr);
    bus.redirect_valid = 1'b0;
    if (force_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = force_pc;
      force_redir        = 0;
    end else if ($urandom_range(99, 0) < p_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = $urandom();
    end
    #1;
    if (redir_prev) check_eq("if_valid_after_redirect", bus.if_valid, 0);
    if (bus.redirect_valid) check_eq("req_valid_in_redirect", bus.imem_req_valid, 0);
    if (stall_prev && !bus.redirect_valid) begin
      check_eq("req_valid_held", bus.imem_req_valid, 1);
      check_eq("req_addr_held", bus.imem_req_addr, prev_addr);
    end
    if (!bus.if_valid) begin
      check_eq("empty_if_pc", bus.if_pc, 0);
      check_eq("empty_if_inst", bus.if_inst, 0);
    end
    if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
      check_eq("if_pc", bus.if_pc, exp_pc);
      check_eq("if_inst", bus.if_inst, mem_word({32'h0, exp_pc}));
      if (want_first) begin
        first_pc = bus.if_pc; want_first = 0; got_first = 1;
      end
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
    if (bus.redirect_valid) begin
      exp_pc = bus.redirect_pc & ~32'd3;
      want_first = 1; got_first = 0;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      mq.push_back('{addr: bus.imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      acc_addr.push_back(bus.imem_req_addr);
      check_eq("inflight_le_depth", (mq.size() <= 4), 1);
    end
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_req_valid = bus.imem_req_valid;
    stall_prev  = bus.imem_req_valid && !bus.imem_req_ready;
    prev_addr   = bus.imem_req_addr;
    redir_prev  = bus.redirect_valid;
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_mode(input int lmin, input int lmax, input int rdy, input int ifr, input int rd);
    lat_min = lmin; lat_max = lmax; p_rdy = rdy; p_ifr = ifr; p_redir = rd;
  endtask

  logic [63:0] got64[8];
  int          n64;
  logic        pend;
  logic [63:0] pend_addr;

  initial begin
    bus64.imem_req_ready = 1'b0;
    bus64.imem_rsp_valid = 1'b0;
    bus64.imem_rsp_data  = '0;
    bus64.redirect_valid = 1'b0;
    bus64.redirect_pc    = '0;
    bus64.if_ready       = 1'b0;

    // Zero-wait memory, decode always ready: one instruction per cycle from cycle 2.
    set_mode(1, 1, 100, 100, 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 2) check_eq("t1_if_valid_early", s_if_valid, 0);
      else begin
        check_eq("t1_if_valid", s_if_valid, 1);
        check_eq("t1_if_pc", s_if_pc, 32'(4 * (i - 2)));
      end
    end

    // Decode stalled: exactly DEPTH requests, then fetch resumes at 0x10 once drained.
    set_mode(1, 1, 100, 0, 0);
    do_reset();
    run(12);
    check_eq("t2_accepted", acc_addr.size(), 4);
    for (int k = 0; k < 4 && k < acc_addr.size(); k++) check_eq("t2_req_addr", acc_addr[k], 32'(4 * k));
    check_eq("t2_req_blocked", s_req_valid, 0);
    p_ifr = 100;
    run(12);
    check_eq("t2_resume_seen", (acc_addr.size() > 4), 1);
    if (acc_addr.size() > 4) check_eq("t2_resume_addr", acc_addr[4], 32'h10);
    check_eq("t2_pops", (n_pops >= 4), 1);

    // Latency 3 with two in flight, redirect to 0x100: late responses dropped.
    set_mode(3, 3, 100, 100, 0);
    do_reset();
    run(2);
    p_rdy = 0; force_redir = 1; force_pc = 32'h100;
    step();
    p_rdy = 100;
    run(12);
    check_eq("t3_first_seen", got_first, 1);
    check_eq("t3_first_pc", first_pc, 32'h100);

    // Redirect while a response arrives and memory is ready; low bits of target ignored.
    set_mode(2, 2, 100, 100, 0);
    do_reset();
    run(6);
    force_redir = 1; force_pc = 32'h103;
    run(12);
    check_eq("t4_first_seen", got_first, 1);
    check_eq("t4_first_pc", first_pc, 32'h100);

    // Back-to-back redirects; the second lands while draining.
    set_mode(3, 3, 100, 100, 0);
    do_reset();
    run(4);
    force_redir = 1; force_pc = 32'h40;
    step();
    force_redir = 1; force_pc = 32'h80;
    run(16);
    check_eq("t5_first_seen", got_first, 1);
    check_eq("t5_first_pc", first_pc, 32'h80);

    // Randomized traffic against the stream scoreboard.
    set_mode(1, 1, 100, 100, 5);
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      lat_min = int'($urandom_range(3, 1));
      lat_max = lat_min + int'($urandom_range(2, 0));
      p_rdy   = int'($urandom_range(100, 30));
      p_ifr   = int'($urandom_range(100, 20));
      run(250);
    end
    check_eq("rand_progress", (n_pops > 100), 1);

    // 64-bit instance: PC wrap past 2^64 and reset mid-stream.
    nrst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 nrst64 = 1'b0;
    check_eq("t6_rst_req_valid", bus64.imem_req_valid, 1);
    check_eq("t6_rst_req_addr", bus64.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    check_eq("t6_rst_if_valid", bus64.if_valid, 0);
    pend = 1'b0; pend_addr = '0; n64 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus64.imem_rsp_valid = pend;
      bus64.imem_rsp_data  = pend ? mem_word(pend_addr) : 32'h0;
      bus64.imem_req_ready = 1'b1;
      bus64.if_ready       = 1'b1;
      #1;
      if (bus64.if_valid && n64 < 8) begin
        got64[n64] = bus64.if_pc;
        check_eq("t6_if_inst", bus64.if_inst, mem_word(bus64.if_pc));
        n64++;
      end
      pend      = bus64.imem_req_valid && bus64.imem_req_ready;
      pend_addr = bus64.imem_req_addr;
      @(posedge clk);
    end
    check_eq("t6_count", (n64 >= 3), 1);
    if (n64 >= 3) begin
      check_eq("t6_pc0", got64[0], 64'hFFFF_FFFF_FFFF_FFF8);
      check_eq("t6_pc1", got64[1], 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("t6_pc2", got64[2], 64'h0);
    end
    @(negedge clk);
    bus64.imem_rsp_valid = 1'b0;
    nrst64 = 1'b1;
    @(posedge clk);
    #1 nrst64 = 1'b0;
    check_eq("t6_mid_rst_if_valid", bus64.if_valid, 0);
    check_eq("t6_mid_rst_addr", bus64.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
